// File: rtl/mem_sequencer.sv
// mem_sequencer: time-shares one single-port memory between CPU fetch and data access, one commit cycle per instruction
module mem_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        im_req,
    input  logic [31:0] im_addr,
    output logic [31:0] im_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        stall,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] instr_cnt,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, FETCH, CHECK, DATA, COMMIT, ERR} state_t;
    state_t state, nxt;
    logic [7:0] wcnt;
    logic d_we;
    logic [31:0] d_addr, d_wdata;
    logic expire;
    assign expire = wcnt == 8'(TIMEOUT - 1);
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = im_req ? FETCH : IDLE;
            FETCH:   nxt = mem_ack ? CHECK : expire ? ERR : FETCH;
            CHECK:   nxt = dm_req ? DATA : COMMIT;
            DATA:    nxt = mem_ack ? COMMIT : expire ? ERR : DATA;
            COMMIT:  nxt = im_req ? FETCH : IDLE;
            default: nxt = ERR;
        endcase
    end
    // outputs decode state and registers only, never mem_ack or mem_rdata
    always_comb begin
        mem_en    = state == FETCH || state == DATA;
        mem_we    = state == DATA && d_we;
        mem_addr  = state == FETCH ? im_addr : state == DATA ? d_addr : 32'd0;
        mem_wdata = mem_we ? d_wdata : 32'd0;
        stall     = state != COMMIT;
        err       = state == ERR;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wcnt      <= 8'd0;
            im_rdata  <= 32'd0;
            dm_rdata  <= 32'd0;
            instr_cnt <= 32'd0;
            d_we      <= 1'b0;
            d_addr    <= 32'd0;
            d_wdata   <= 32'd0;
        end else begin
            state <= nxt;
            wcnt  <= (mem_en && nxt == state) ? wcnt + 8'd1 : 8'd0;
            if (state == FETCH && mem_ack) im_rdata <= mem_rdata;
            if (state == DATA && mem_ack && !d_we) dm_rdata <= mem_rdata;
            if (state == CHECK && dm_req) begin
                d_we    <= dm_we;
                d_addr  <= dm_addr;
                d_wdata <= dm_wdata;
            end
            if (state == COMMIT) instr_cnt <= instr_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer: randomized instruction stream against a transaction-level memory/CPU model
module tb_mem_sequencer;
    localparam int TO = 4;
    logic clk = 1'b0, reset, im_req, dm_req, dm_we, mem_ack, stall, mem_en, mem_we, err;
    logic [31:0] im_addr, im_rdata, dm_addr, dm_wdata, dm_rdata, mem_addr, mem_wdata, mem_rdata, instr_cnt;
    int n_cmp = 0, n_bad = 0;
    logic [31:0] exp_cnt, exp_dm, exp_im;
    logic [31:0] mem [logic [31:0]];
    logic ab;

    mem_sequencer #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .stall(stall), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .instr_cnt(instr_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic check_rst(input string tag);
        check({tag, "_stall"}, stall, 1);
        check({tag, "_en"}, mem_en, 0);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_im"}, im_rdata, 0);
        check({tag, "_dm"}, dm_rdata, 0);
        check({tag, "_cnt"}, instr_cnt, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic expect_err;
        for (int k = 0; k < 3; k++) begin
            check("e_err", err, 1);
            check("e_stall", stall, 1);
            check("e_en", mem_en, 0);
            check("e_addr", mem_addr, 0);
            mem_ack = 1'b1;
            mem_rdata = $urandom;
            im_req = 1'b1;
            tick;
        end
        mem_ack = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        mem_ack = 1'b0;
        tick;
        check_rst("rst");
        exp_cnt = 0;
        exp_dm = 0;
        reset = 1'b0;
    endtask

    // entered at the negedge of the first FETCH cycle; lf/ld = wait cycles before ack (>= TO means no ack)
    task automatic run_instr(input logic [31:0] ia, input int lf, input logic dm, input logic we,
                             input logic [31:0] da, input logic [31:0] wd, input int ld, input int rcyc,
                             input logic next_req, output logic aborted);
        logic [31:0] word, rd;
        aborted = 1'b0;
        im_addr = ia;
        #1;
        word = mem.exists(ia) ? mem[ia] : $urandom;
        for (int k = 0; k <= lf && k < TO; k++) begin
            check("f_en", mem_en, 1);
            check("f_we", mem_we, 0);
            check("f_addr", mem_addr, ia);
            check("f_wdata", mem_wdata, 0);
            check("f_stall", stall, 1);
            check("f_err", err, 0);
            mem_ack = k == lf;
            mem_rdata = k == lf ? word : $urandom;
            dm_req = $urandom;
            tick;
        end
        if (lf >= TO) begin
            expect_err;
            aborted = 1'b1;
            return;
        end
        exp_im = word;
        check("c_im", im_rdata, exp_im);
        check("c_en", mem_en, 0);
        check("c_addr", mem_addr, 0);
        check("c_stall", stall, 1);
        dm_req = dm;
        dm_we = we;
        dm_addr = da;
        dm_wdata = wd;
        mem_ack = $urandom;
        mem_rdata = $urandom;
        tick;
        if (dm) begin
            rd = mem.exists(da) ? mem[da] : $urandom;
            for (int k = 0; k <= ld && k < TO; k++) begin
                check("d_en", mem_en, 1);
                check("d_we", mem_we, we);
                check("d_addr", mem_addr, da);
                check("d_wdata", mem_wdata, we ? wd : 32'd0);
                check("d_stall", stall, 1);
                check("d_im", im_rdata, exp_im);
                if (k == rcyc) begin
                    reset = 1'b1;
                    mem_ack = 1'b0;
                    tick;
                    aborted = 1'b1;
                    return;
                end
                dm_req = $urandom;
                dm_we = $urandom;
                dm_addr = $urandom;
                dm_wdata = $urandom;
                mem_ack = k == ld;
                mem_rdata = k == ld ? rd : $urandom;
                tick;
                if (k == ld) begin
                    if (we) mem[da] = wd;
                    else exp_dm = rd;
                end
            end
            if (ld >= TO) begin
                expect_err;
                aborted = 1'b1;
                return;
            end
        end
        check("m_stall", stall, 0);
        check("m_en", mem_en, 0);
        check("m_dm", dm_rdata, exp_dm);
        check("m_im", im_rdata, exp_im);
        check("m_cnt", instr_cnt, exp_cnt);
        im_req = next_req;
        mem_ack = $urandom;
        dm_req = $urandom;
        tick;
        exp_cnt = exp_cnt + 1;
        check("a_cnt", instr_cnt, exp_cnt);
        check("a_stall", stall, 1);
        check("a_en", mem_en, next_req);
    endtask

    initial begin
        reset = 1'b1;
        im_req = 1'b1;
        im_addr = 32'h00400000;
        dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        mem[32'h00400000] = 32'h20080005;
        mem[32'h10010004] = 32'hDEADBEEF;
        exp_cnt = 0;
        exp_dm = 0;
        tick;
        tick;
        check_rst("init");
        reset = 1'b0;
        mem_ack = 1'b0;
        tick;
        run_instr(32'h00400000, 0, 0, 0, 0, 0, 0, -1, 1, ab);
        run_instr(32'h00400004, 0, 1, 0, 32'h10010004, 0, 2, -1, 1, ab);
        run_instr(32'h00400008, 0, 1, 1, 32'h10010008, 32'h12345678, 0, -1, 1, ab);
        run_instr(32'h0040000C, TO - 1, 0, 0, 0, 0, 0, -1, 1, ab);
        for (int i = 0; i < 150; i++) begin
            logic nx;
            nx = $urandom_range(0, 3) != 0;
            run_instr(32'h00400000 + 32'(i * 4), $urandom_range(0, TO - 1), 1'($urandom),
                      1'($urandom), 32'h10010000 + 32'($urandom_range(0, 15) * 4), $urandom,
                      $urandom_range(0, TO - 1), -1, nx, ab);
            if (!nx) begin
                for (int j = $urandom_range(0, 2); j >= 0; j--) begin
                    check("i_en", mem_en, 0);
                    check("i_stall", stall, 1);
                    check("i_cnt", instr_cnt, exp_cnt);
                    mem_ack = $urandom;
                    tick;
                end
                im_req = 1'b1;
                tick;
            end
        end
        run_instr(32'h00400100, 0, 1, 0, 32'h10010004, 0, 5, 1, 1, ab);
        check("r_abort", ab, 1);
        check_rst("mid");
        exp_cnt = 0;
        exp_dm = 0;
        reset = 1'b0;
        im_req = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = $urandom;
        tick;
        check_rst("late");
        im_req = 1'b1;
        mem_ack = 1'b0;
        tick;
        run_instr(32'h00400200, TO, 0, 0, 0, 0, 0, -1, 1, ab);
        do_reset;
        tick;
        run_instr(32'h00400204, 0, 1, 1, 32'h10010020, 32'hA5A5A5A5, TO, -1, 1, ab);
        do_reset;
        im_req = 1'b0;
        tick;
        check("w_en", mem_en, 0);
        dut.instr_cnt = 32'hFFFFFFFF;
        exp_cnt = 32'hFFFFFFFF;
        im_req = 1'b1;
        tick;
        run_instr(32'h00400300, 1, 0, 0, 0, 0, 0, -1, 0, ab);
        check("w_zero", instr_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Sequencer that lets the single-cycle CPU run from one shared single-port memory. Per instruction it fetches the instruction, optionally performs the data access, then releases the CPU for exactly one commit cycle. It sits between the CPU's IM_R/DM_CS/DM_R/DM_W/maddr/mwdata/mrdata signals and the physical memory, and gates CPU state updates through `stall`. It also counts retired instructions and traps memory timeouts.

## Interface
- TIMEOUT, 15: maximum cycles an access may wait for `mem_ack` (1..255)
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- im_req  in  1  CPU instruction read request (IM_R)
- im_addr  in  32  instruction address (pc_out)
- im_rdata  out  32  registered instruction word to the CPU `inst` input
- dm_req  in  1  CPU data access request (DM_CS)
- dm_we  in  1  data write (DM_W); 0 = read
- dm_addr  in  32  data address (maddr)
- dm_wdata  in  32  data write value (mwdata)
- dm_rdata  out  32  registered load data to the CPU `mrdata` input
- stall  out  1  1 = CPU must hold PC, register file and data memory state
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid when `mem_ack`=1
- mem_ack  in  1  access complete; may be asserted in the same cycle as `mem_en`
- instr_cnt  out  32  retired-instruction counter
- err  out  1  sticky timeout flag

## Operation
- States: IDLE, FETCH, CHECK, DATA, COMMIT, ERR.
- IDLE: `stall`=1, `mem_en`=0. Next state is FETCH when `im_req`=1; otherwise stay in IDLE.
- FETCH: `mem_en`=1, `mem_we`=0, `mem_addr`=`im_addr`.
  - On `mem_ack`, capture `mem_rdata` into `im_rdata` and go to CHECK.
- CHECK: one cycle with no memory access, so the CPU can decode the new `im_rdata`.
  - If `dm_req`=1, register `dm_addr`, `dm_we` and `dm_wdata`, then go to DATA.
  - Otherwise go to COMMIT.
- DATA: `mem_en`=1, with `mem_we`, `mem_addr` and `mem_wdata` driven from the registered copies.
  - On `mem_ack`: for a read, capture `mem_rdata` into `dm_rdata`; for a write, leave `dm_rdata` unchanged. Then go to COMMIT.
- COMMIT: `stall`=0 for exactly one cycle. `instr_cnt` increments by 1 (mod 2^32, wraps to 0). Then go to FETCH if `im_req`=1, otherwise IDLE.
- `stall`=1 in every state except COMMIT.
- Outside FETCH and DATA: `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- `mem_wdata`=0 during FETCH and during DATA reads.
- Timeout:
  - An 8-bit wait counter clears on entry to FETCH or DATA and increments every cycle in that state without `mem_ack`.
  - `mem_ack` on any of the first TIMEOUT cycles of the state completes the access. An ack on exactly cycle TIMEOUT still succeeds.
  - If cycle TIMEOUT ends without ack, go to ERR.
- ERR: `err`=1, `stall`=1, `mem_en`=0. Only reset leaves ERR.
- `mem_ack` outside FETCH and DATA is ignored.
- `dm_req` or `dm_addr` changing during DATA has no effect, because the access uses the registered values.

## Timing
- Reset takes effect at any state, mid-access included. On the next edge:
  - state=IDLE; `stall`=1; `mem_en`=0; `mem_we`=0; `mem_addr`=0; `mem_wdata`=0.
  - `im_rdata`=0; `dm_rdata`=0; `instr_cnt`=0; `err`=0; wait counter=0.
  - An in-flight access is abandoned. A late `mem_ack` after reset is ignored.
- With zero-wait memory (ack in the same cycle as `mem_en`), steady-state cycles per instruction:
  - No data access: 3 (FETCH, CHECK, COMMIT).
  - With data access: 4 (FETCH, CHECK, DATA, COMMIT).
  - Each additional wait cycle adds 1 per access.
- `im_rdata` and `dm_rdata` update on the edge that ends the acked cycle. They are stable throughout CHECK, DATA and COMMIT.
- `instr_cnt` shows the incremented value from the cycle after COMMIT.
- All outputs are decoded from registered state and registers. None depends combinationally on `mem_ack` or `mem_rdata`.

## Test plan
- **Reset and first fetch.** Hold reset for 2 cycles, then `im_req`=1, `im_addr`=0x00400000, zero-wait memory returning 0x20080005, `dm_req`=0.
  - Required: `mem_en` rises 1 cycle after reset release with `mem_addr`=0x00400000.
  - `im_rdata`=0x20080005 in CHECK.
  - `stall`=0 for exactly one cycle, 2 cycles after FETCH.
  - `instr_cnt`=1.
- **Load with 2 wait states.** `dm_req`=1, `dm_we`=0, `dm_addr`=0x10010004, memory returns 0xDEADBEEF.
  - Required: DATA lasts 3 cycles with `mem_we`=0.
  - `dm_rdata`=0xDEADBEEF before COMMIT.
  - Instruction takes 6 cycles in total.
- **Store.** `dm_we`=1, `dm_wdata`=0x12345678, `dm_addr`=0x10010008.
  - Required: one DATA cycle with `mem_we`=1, `mem_wdata`=0x12345678, `mem_addr`=0x10010008.
  - `dm_rdata` unchanged.
- **Timeout boundary.** TIMEOUT=4.
  - Ack on cycle 4 of FETCH: access completes, `err`=0.
  - No ack in 4 cycles: ERR, `err`=1, `stall` stays 1, `mem_en`=0.
  - A subsequent ack is ignored; reset clears `err`.
- **Reset mid-DATA and counter wrap.**
  - Assert reset on cycle 2 of a waiting DATA access; required: IDLE, all outputs at their reset values, late ack ignored.
  - Force `instr_cnt` to 0xFFFFFFFF via 2^32-1 commits (or a backdoor preload); the next COMMIT gives 0.
